// File: rtl/lsu_pkg.sv
// Shared constants, state encoding and fault classification for the load/store unit.
package lsu_pkg;

    localparam logic [2:0] F3_B  = 3'd0;
    localparam logic [2:0] F3_H  = 3'd1;
    localparam logic [2:0] F3_W  = 3'd2;
    localparam logic [2:0] F3_BU = 3'd4;
    localparam logic [2:0] F3_HU = 3'd5;

    localparam int DEFAULT_TIMEOUT = 255;

    typedef enum logic [1:0] {IDLE, WAIT, DONE, FAULT} lsu_state_t;

    // Illegal size encodings, misalignment, or a simultaneous load+store.
    function automatic logic is_fault(logic rd, logic wr, logic [2:0] f3, logic [1:0] off);
        logic bad_f3, misal;
        bad_f3 = wr ? (f3 > F3_W) : (f3 == 3'd3 || f3 >= 3'd6);
        misal  = (f3[1:0] == 2'd1 && off[0]) || (f3[1:0] == 2'd2 && off != 2'd0);
        return (rd & wr) | bad_f3 | misal;
    endfunction

endpackage

// File: rtl/lsu_bus_if.sv
// External memory bus between the load/store unit (master) and memory (slave).
interface lsu_bus_if;
    logic        req;
    logic        we;
    logic [31:0] addr;
    logic [3:0]  be;
    logic [31:0] wdata;
    logic        ack;
    logic [31:0] rdata;

    modport master (output req, we, addr, be, wdata, input  ack, rdata);
    modport slave  (input  req, we, addr, be, wdata, output ack, rdata);
endinterface

// File: rtl/load_align.sv
// Selects the addressed byte/halfword of a read word and sign/zero extends it.
module load_align
    import lsu_pkg::*;
(
    input  logic [31:0] word,
    input  logic [1:0]  off,
    input  logic [2:0]  f3,
    output logic [31:0] data
);
    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    assign byte_sel = word[{off, 3'b000} +: 8];
    assign half_sel = off[1] ? word[31:16] : word[15:0];

    always_comb begin
        data = word;
        case (f3)
            F3_B:    data = {{24{byte_sel[7]}}, byte_sel};
            F3_H:    data = {{16{half_sel[15]}}, half_sel};
            F3_BU:   data = {24'd0, byte_sel};
            F3_HU:   data = {16'd0, half_sel};
            default: data = word;
        endcase
    end
endmodule

// File: rtl/load_store_unit.sv
// Single-outstanding load/store unit: accepts a MEM-stage request, drives one bus
// access, and stalls the pipeline until the extended result is ready.
module load_store_unit
    import lsu_pkg::*;
#(
    parameter int TIMEOUT = DEFAULT_TIMEOUT
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        enable,
    input  logic        mem_rd,
    input  logic        mem_wr,
    input  logic [2:0]  funct3,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    output logic [31:0] rdata,
    output logic        stall,
    output logic        err,
    lsu_bus_if.master   bus
);
    localparam logic [15:0] TO_LAST = 16'(TIMEOUT - 1);

    lsu_state_t  state;
    logic [15:0] wait_cnt;
    logic [2:0]  ld_f3;
    logic [1:0]  ld_off;
    logic        st_q;
    logic        req_any, req_fault;
    logic [3:0]  st_be;
    logic [31:0] st_wdata, ld_data;

    assign req_any   = enable & (mem_rd | mem_wr);
    assign req_fault = is_fault(mem_rd, mem_wr, funct3, addr[1:0]);
    assign stall     = (state == IDLE && req_any && !req_fault) || state == WAIT;

    always_comb begin
        st_be    = 4'b1111;
        st_wdata = wdata;
        case (funct3[1:0])
            2'd0: begin st_be = 4'b0001 << addr[1:0]; st_wdata = {4{wdata[7:0]}};  end
            2'd1: begin st_be = 4'b0011 << addr[1:0]; st_wdata = {2{wdata[15:0]}}; end
            default: ;
        endcase
    end

    load_align u_align (.word(bus.rdata), .off(ld_off), .f3(ld_f3), .data(ld_data));

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            wait_cnt  <= '0;
            ld_f3     <= '0;
            ld_off    <= '0;
            st_q      <= 1'b0;
            rdata     <= '0;
            err       <= 1'b0;
            bus.req   <= 1'b0;
            bus.we    <= 1'b0;
            bus.addr  <= '0;
            bus.be    <= '0;
            bus.wdata <= '0;
        end else begin
            case (state)
                IDLE: if (req_any) begin
                    if (req_fault) begin
                        state <= FAULT;
                        err   <= 1'b1;
                        rdata <= '0;
                    end else begin
                        state     <= WAIT;
                        wait_cnt  <= '0;
                        ld_f3     <= funct3;
                        ld_off    <= addr[1:0];
                        st_q      <= mem_wr;
                        bus.req   <= 1'b1;
                        bus.we    <= mem_wr;
                        bus.addr  <= {addr[31:2], 2'b00};
                        bus.be    <= mem_wr ? st_be : 4'b1111;
                        bus.wdata <= mem_wr ? st_wdata : '0;
                    end
                end
                WAIT: begin
                    wait_cnt <= wait_cnt + 16'd1;
                    // An ack on the last allowed cycle still completes the access.
                    if (bus.ack) begin
                        bus.req <= 1'b0;
                        state   <= DONE;
                        if (!st_q) rdata <= ld_data;
                    end else if (wait_cnt == TO_LAST) begin
                        bus.req <= 1'b0;
                        state   <= FAULT;
                        err     <= 1'b1;
                        rdata   <= '0;
                    end
                end
                DONE:  state <= IDLE;
                FAULT: begin
                    err   <= 1'b0;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_load_store_unit.sv
// Directed bench for load_store_unit (built with TIMEOUT=4).
module tb_load_store_unit;
    logic        clk = 1'b0;
    logic        rst, enable, mem_rd, mem_wr;
    logic [2:0]  funct3;
    logic [31:0] addr, wdata, rdata;
    logic        stall, err;
    int          passed = 0;
    int          total  = 0;

    lsu_bus_if bus ();

    load_store_unit #(.TIMEOUT(4)) dut (
        .clk(clk), .rst(rst), .enable(enable), .mem_rd(mem_rd), .mem_wr(mem_wr),
        .funct3(funct3), .addr(addr), .wdata(wdata), .rdata(rdata),
        .stall(stall), .err(err), .bus(bus)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    endtask

    task automatic drive(input logic rd, input logic wr, input logic [2:0] f3,
                         input logic [31:0] a, input logic [31:0] wd);
        enable = 1'b1; mem_rd = rd; mem_wr = wr; funct3 = f3; addr = a; wdata = wd;
        #1;
    endtask

    task automatic idle_in();
        mem_rd = 1'b0; mem_wr = 1'b0;
    endtask

    // Accept edge, then one WAIT cycle with ack; returns at the DONE cycle.
    task automatic ack_once(input logic [31:0] word);
        bus.ack = 1'b1; bus.rdata = word;
        step();
        bus.ack = 1'b0; bus.rdata = 32'h0;
    endtask

    initial begin
        rst = 1'b1; enable = 1'b0; mem_rd = 1'b0; mem_wr = 1'b0;
        funct3 = 3'd0; addr = 32'h0; wdata = 32'h0;
        bus.ack = 1'b0; bus.rdata = 32'h0;
        step(); step();
        chk("rst_req",   32'(bus.req), 32'd0);
        chk("rst_stall", 32'(stall),   32'd0);
        chk("rst_err",   32'(err),     32'd0);
        chk("rst_rdata", rdata,        32'd0);
        chk("rst_be",    32'(bus.be),  32'd0);
        rst = 1'b0;
        step();

        // LW 0x100, ack in the first WAIT cycle
        drive(1, 0, 3'd2, 32'h100, 32'h0);
        chk("lw_stall_acc", 32'(stall), 32'd1);
        step(); idle_in();
        chk("lw_req",   32'(bus.req), 32'd1);
        chk("lw_stall_wait", 32'(stall), 32'd1);
        chk("lw_be",    32'(bus.be),  32'hF);
        chk("lw_addr",  bus.addr,     32'h100);
        chk("lw_we",    32'(bus.we),  32'd0);
        ack_once(32'hDEADBEEF);
        chk("lw_done_stall", 32'(stall), 32'd0);
        chk("lw_done_req",   32'(bus.req), 32'd0);
        chk("lw_rdata",      rdata, 32'hDEADBEEF);
        step();
        chk("lw_hold", rdata, 32'hDEADBEEF);

        // LB / LBU at 0x103, LH at 0x102 on word 0x80FF0000
        drive(1, 0, 3'd0, 32'h103, 32'h0); step(); idle_in();
        chk("lb_addr", bus.addr, 32'h100);
        ack_once(32'h80FF0000);
        chk("lb_rdata", rdata, 32'hFFFFFF80);
        step();
        drive(1, 0, 3'd4, 32'h103, 32'h0); step(); idle_in();
        ack_once(32'h80FF0000);
        chk("lbu_rdata", rdata, 32'h00000080);
        step();
        drive(1, 0, 3'd1, 32'h102, 32'h0); step(); idle_in();
        ack_once(32'h80FF0000);
        chk("lh_rdata", rdata, 32'hFFFF80FF);
        step();

        // SB 0x101, SH 0x102; stores leave rdata alone
        drive(0, 1, 3'd0, 32'h101, 32'h000000AB); step(); idle_in();
        chk("sb_be",    32'(bus.be),  32'h2);
        chk("sb_wdata", bus.wdata,    32'hABABABAB);
        chk("sb_we",    32'(bus.we),  32'd1);
        chk("sb_addr",  bus.addr,     32'h100);
        ack_once(32'h55555555);
        chk("sb_rdata_keep", rdata, 32'hFFFF80FF);
        step();
        drive(0, 1, 3'd1, 32'h102, 32'h00001234); step(); idle_in();
        chk("sh_be",    32'(bus.be), 32'hC);
        chk("sh_wdata", bus.wdata,   32'h12341234);
        ack_once(32'h0);
        step();

        // Misaligned LW faults
        drive(1, 0, 3'd2, 32'h102, 32'h0);
        chk("mis_stall", 32'(stall), 32'd0);
        step(); idle_in();
        chk("mis_err",   32'(err),     32'd1);
        chk("mis_req",   32'(bus.req), 32'd0);
        chk("mis_stall_f", 32'(stall), 32'd0);
        chk("mis_rdata", rdata,        32'd0);
        step();
        chk("mis_err_clr", 32'(err), 32'd0);

        // Reload something nonzero, then rd & wr together faults
        drive(1, 0, 3'd2, 32'h0, 32'h0); step(); idle_in();
        ack_once(32'h11223344);
        chk("lw2_rdata", rdata, 32'h11223344);
        step();
        drive(1, 1, 3'd2, 32'h0, 32'h0);
        chk("rw_stall", 32'(stall), 32'd0);
        step(); idle_in();
        chk("rw_err",   32'(err),     32'd1);
        chk("rw_req",   32'(bus.req), 32'd0);
        chk("rw_rdata", rdata,        32'd0);
        step();
        chk("rw_err_clr", 32'(err), 32'd0);

        // Illegal load funct3 = 6
        drive(1, 0, 3'd6, 32'h0, 32'h0); step(); idle_in();
        chk("f3_err", 32'(err), 32'd1);
        step();

        // Timeout: bus_req high for 4 WAIT cycles, then FAULT
        drive(1, 0, 3'd2, 32'h200, 32'h0); step(); idle_in();
        for (int i = 0; i < 4; i++) begin
            chk($sformatf("to_req%0d", i),   32'(bus.req), 32'd1);
            chk($sformatf("to_stall%0d", i), 32'(stall),   32'd1);
            chk($sformatf("to_err%0d", i),   32'(err),     32'd0);
            step();
        end
        chk("to_req_drop", 32'(bus.req), 32'd0);
        chk("to_err",      32'(err),     32'd1);
        chk("to_stall_f",  32'(stall),   32'd0);
        // Late ack arriving in IDLE is ignored
        bus.ack = 1'b1; bus.rdata = 32'h77777777;
        step();
        bus.ack = 1'b0;
        chk("late_err",   32'(err),     32'd0);
        chk("late_req",   32'(bus.req), 32'd0);
        chk("late_rdata", rdata,        32'd0);
        step();
        chk("late_stall", 32'(stall), 32'd0);

        // Reset in the second WAIT cycle aborts the access
        drive(1, 0, 3'd2, 32'h300, 32'h0); step(); idle_in();
        step();
        chk("rstw_req_before", 32'(bus.req), 32'd1);
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk("rstw_req",   32'(bus.req), 32'd0);
        chk("rstw_err",   32'(err),     32'd0);
        chk("rstw_stall", 32'(stall),   32'd0);
        drive(1, 0, 3'd2, 32'h0, 32'h0);
        chk("post_stall", 32'(stall), 32'd1);
        step(); idle_in();
        chk("post_req",  32'(bus.req), 32'd1);
        chk("post_addr", bus.addr,     32'h0);
        ack_once(32'hCAFEF00D);
        chk("post_rdata", rdata, 32'hCAFEF00D);
        step();

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
